// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: FSM states, hb encodings, default windows.
// Ports: none (package only).
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HB_WORD = 2'b00,
    HB_HALF = 2'b01,
    HB_BYTE = 2'b10
  } hb_t;

  localparam logic [31:0] ROM_BASE_DEF  = 32'h0000_0000;
  localparam logic [31:0] RAM_BASE_DEF  = 32'h0000_1000;
  localparam logic [31:0] UART_BASE_DEF = 32'h0000_2000;

  localparam logic [31:0] ROM_SIZE  = 32'h0000_1000;
  localparam logic [31:0] RAM_SIZE  = 32'h0000_1000;
  localparam logic [31:0] UART_SIZE = 32'h0000_0010;

  // Unsigned offset compare: addresses below base wrap to huge offsets
  function automatic logic in_win(
    input logic [31:0] a,
    input logic [31:0] base,
    input logic [31:0] size
  );
    return (a - base) < size;
  endfunction

endpackage

// File: rtl/bus_decoder.sv
// Address decoder: maps an address onto one-hot slave selects.
// Ports: i_addr in 32; o_cs out 3 {uart,ram,rom}; o_err out 1 (unmapped).
module bus_decoder
  import bus_arbiter_pkg::*;
#(
  parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
  parameter logic [31:0] UART_BASE = UART_BASE_DEF
) (
  input  logic [31:0] i_addr,
  output logic [2:0]  o_cs,
  output logic        o_err
);

  always_comb begin
    o_cs    = 3'b000;
    o_cs[0] = in_win(i_addr, ROM_BASE, ROM_SIZE);
    o_cs[1] = in_win(i_addr, RAM_BASE, RAM_SIZE);
    o_cs[2] = in_win(i_addr, UART_BASE, UART_SIZE);
  end

  assign o_err = ~|o_cs;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, three-slave bus arbiter with IDLE/ACCESS/RESP FSM.
// Ports: clk_i, rst_i (async, active-high); per master m0/m1:
//   req/we/addr/wdata/hb in, gnt/ack/rdata out; bus_addr/data/we/hb/cs
//   out to slaves; rom/ram/uart_data_i in; bus_err_o sticky unmapped flag.
// Option: define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration,
//   otherwise m0 has fixed priority.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
  parameter logic [31:0] UART_BASE = UART_BASE_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [1:0]  m0_hb_i,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [1:0]  m1_hb_i,
  output logic        m0_gnt_o,
  output logic        m0_ack_o,
  output logic [31:0] m0_rdata_o,
  output logic        m1_gnt_o,
  output logic        m1_ack_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  output logic        bus_we_o,
  output logic [1:0]  bus_hb_o,
  output logic [2:0]  bus_cs_o,
  input  logic [31:0] rom_data_i,
  input  logic [31:0] ram_data_i,
  input  logic [31:0] uart_data_i,
  output logic        bus_err_o
);

  state_t      r_state;
  logic        r_mid;
  logic [1:0]  r_gnt;
  logic [1:0]  r_ack;

  logic        w_any;
  logic        w_sel;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [1:0]  w_hb;
  logic [2:0]  w_cs;
  logic        w_err;
  logic [31:0] w_rd;

  assign w_any = m0_req_i | m1_req_i;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Master granted most recently; reset to m1 so m0 wins first
  logic r_last;

  assign w_sel = (m0_req_i & m1_req_i) ? ~r_last : m1_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
    end else if (r_state == ST_IDLE && w_any) begin
      r_last <= w_sel;
    end
  end
`else
  assign w_sel = ~m0_req_i;
`endif

  assign w_we    = w_sel ? m1_we_i    : m0_we_i;
  assign w_addr  = w_sel ? m1_addr_i  : m0_addr_i;
  assign w_wdata = w_sel ? m1_wdata_i : m0_wdata_i;
  assign w_hb    = w_sel ? m1_hb_i    : m0_hb_i;

  bus_decoder #(
    .ROM_BASE  (ROM_BASE),
    .RAM_BASE  (RAM_BASE),
    .UART_BASE (UART_BASE)
  ) u_dec (
    .i_addr (w_addr),
    .o_cs   (w_cs),
    .o_err  (w_err)
  );

  // Slave read mux keyed by the select driven during ACCESS
  always_comb begin
    w_rd = 32'h0;
    unique case (1'b1)
      bus_cs_o[0]: w_rd = rom_data_i;
      bus_cs_o[1]: w_rd = ram_data_i;
      bus_cs_o[2]: w_rd = uart_data_i;
      default:     w_rd = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_mid      <= 1'b0;
      r_gnt      <= 2'b00;
      r_ack      <= 2'b00;
      bus_we_o   <= 1'b0;
      bus_cs_o   <= 3'b000;
      bus_addr_o <= 32'h0;
      bus_data_o <= 32'h0;
      bus_hb_o   <= 2'b00;
      bus_err_o  <= 1'b0;
      m0_rdata_o <= 32'h0;
      m1_rdata_o <= 32'h0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_ACCESS;
            r_mid      <= w_sel;
            r_gnt      <= w_sel ? 2'b10 : 2'b01;
            bus_we_o   <= w_we;
            bus_cs_o   <= w_cs;
            bus_addr_o <= w_addr;
            bus_data_o <= w_wdata;
            bus_hb_o   <= w_hb;
            if (w_err) bus_err_o <= 1'b1;
          end
        end
        ST_ACCESS: begin
          r_state  <= ST_RESP;
          r_gnt    <= 2'b00;
          r_ack    <= r_gnt;
          bus_we_o <= 1'b0;
          bus_cs_o <= 3'b000;
          if (!bus_we_o) begin
            if (r_mid) m1_rdata_o <= w_rd;
            else       m0_rdata_o <= w_rd;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ack   <= 2'b00;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m0_gnt_o = r_gnt[0];
  assign m1_gnt_o = r_gnt[1];
  assign m0_ack_o = r_ack[0];
  assign m1_ack_o = r_ack[1];

endmodule
